// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC datapath: default sizes, accumulator
// width derivation, thermometer-to-index and element slicing.
package mac_pkg;

  localparam int DEF_SIZE   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int VEC_MAX_W  = 256;

  function automatic int acc_width(input int data_w, input int size);
    return 2 * data_w + $clog2(size) + 1;
  endfunction

  // Highest set bit wins, so malformed (non-thermometer) selects still decode.
  function automatic int msb_index(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [31:0] elem_slice(input logic [VEC_MAX_W-1:0] vec,
                                             input int idx, input int w);
    return 32'(vec >> (idx * w));
  endfunction

endpackage

// File: rtl/mac_datapath_if.sv
// Control strobes, operand vectors and result handshake between the matrix
// control FSM / writeback stage (master) and the MAC datapath (slave).
// With MAC_SATURATE_EN defined the sat_flag signal is added.
interface mac_datapath_if
  import mac_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_SIZE)
);
  logic                     load_en;
  logic                     mult_en;
  logic                     acc_en;
  logic [SIZE-1:0]          memsel;
  logic                     done;
  logic [SIZE*DATA_W-1:0]   row_data;
  logic [SIZE*DATA_W-1:0]   col_data;
  logic [ACC_W-1:0]         result;
  logic                     result_valid;
  logic                     result_ready;
  logic [$clog2(SIZE):0]    elem_count;
  logic                     sel_err;
  logic                     overrun;
`ifdef MAC_SATURATE_EN
  logic                     sat_flag;
`endif

  modport master (
    output load_en, mult_en, acc_en, memsel, done, row_data, col_data, result_ready,
    input  result, result_valid, elem_count, sel_err, overrun
`ifdef MAC_SATURATE_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  load_en, mult_en, acc_en, memsel, done, row_data, col_data, result_ready,
    output result, result_valid, elem_count, sel_err, overrun
`ifdef MAC_SATURATE_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/mac_datapath_memsel_decode.sv
// Thermometer element select to operand index, plus an all-zero flag used to
// force the operand registers to zero and raise sel_err.
module memsel_decode
  import mac_pkg::*;
#(
  parameter int  SIZE  = DEF_SIZE,
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0]  memsel,
  output logic [IDX_W-1:0] idx,
  output logic             sel_zero
);

  assign idx      = IDX_W'(msb_index(32'(memsel)));
  assign sel_zero = (memsel == '0);

endmodule

// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath: load/mult/acc pipeline with a valid/ready result
// register. Define MAC_SATURATE_EN for a clamping accumulator and sat_flag output.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = acc_width(DATA_W, SIZE)
) (
  input  logic           clk,
  input  logic           reset,
  mac_datapath_if.slave  bus
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(SIZE) + 1;

  logic [IDX_W-1:0]    idx;
  logic                sel_zero;
  logic [DATA_W-1:0]   row_elem;
  logic [DATA_W-1:0]   col_elem;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [2*DATA_W-1:0] prod_reg;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    final_sum;
  logic                sat_hit;
  logic                accept;
  logic [ACC_W-1:0]    result_q;
  logic                result_valid_q;
  logic [CNT_W-1:0]    elem_count_q;
  logic                sel_err_q;
  logic                overrun_q;

  memsel_decode #(.SIZE(SIZE)) u_memsel_decode (
    .memsel   (bus.memsel),
    .idx      (idx),
    .sel_zero (sel_zero)
  );

  assign row_elem = DATA_W'(elem_slice(VEC_MAX_W'(bus.row_data), int'(idx), DATA_W));
  assign col_elem = DATA_W'(elem_slice(VEC_MAX_W'(bus.col_data), int'(idx), DATA_W));
  assign prod_ext = ACC_W'(prod_reg);

  always_comb begin
    acc_sum = '0;
    sat_hit = 1'b0;
`ifdef MAC_SATURATE_EN
    begin
      logic [ACC_W:0] raw;
      raw     = {1'b0, acc} + {1'b0, prod_ext};
      sat_hit = raw[ACC_W];
      acc_sum = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    end
`else
    acc_sum = acc + prod_ext;
`endif
  end

  // A coincident acc_en folds the last product into the captured sum.
  assign final_sum = bus.acc_en ? acc_sum : acc;
  assign accept    = !result_valid_q || bus.result_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg          <= '0;
      b_reg          <= '0;
      prod_reg       <= '0;
      acc            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      elem_count_q   <= '0;
      sel_err_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (bus.load_en) begin
        a_reg <= sel_zero ? '0 : row_elem;
        b_reg <= sel_zero ? '0 : col_elem;
        if (sel_zero) sel_err_q <= 1'b1;
      end
      if (bus.mult_en) prod_reg <= a_reg * b_reg;

      if (bus.done) begin
        acc          <= '0;
        elem_count_q <= '0;
        if (accept) begin
          result_q       <= final_sum;
          result_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else begin
        if (bus.acc_en) begin
          acc          <= acc_sum;
          elem_count_q <= elem_count_q + 1'b1;
        end
        if (result_valid_q && bus.result_ready) result_valid_q <= 1'b0;
      end
    end
  end

`ifdef MAC_SATURATE_EN
  logic sat_flag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag_q <= 1'b0;
    end else if (bus.done && accept) begin
      sat_flag_q <= 1'b0;
    end else if (bus.acc_en && sat_hit) begin
      sat_flag_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_flag_q;
`endif

  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.elem_count   = elem_count_q;
  assign bus.sel_err      = sel_err_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/mac_datapath.md
Name: mac_datapath

Overview:
- Multiply-accumulate datapath directly downstream of the matrix control FSM.
- Consumes the per-phase strobes load_en / mult_en / acc_en, the thermometer element select memsel and the done pulse.
- Produces one dot-product result per operation through a valid/ready output register.
- Feeds the result writeback stage of the matrix processor.

Parameters:
- SIZE, 4: elements per row/column vector; memsel width.
- DATA_W, 8: unsigned operand width.
- ACC_W, 2*DATA_W+$clog2(SIZE)+1: accumulator and result width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  operand load strobe.
- mult_en  in  1  multiply strobe.
- acc_en  in  1  accumulate strobe.
- memsel  in  SIZE  thermometer element select (0001, 0011, 0111, 1111…).
- done  in  1  end-of-operation pulse.
- row_data  in  SIZE*DATA_W  row vector; element i at bits [i*DATA_W +: DATA_W].
- col_data  in  SIZE*DATA_W  column vector, same packing.
- result  out  ACC_W  captured dot product.
- result_valid  out  1  result holds unconsumed data.
- result_ready  in  1  consumer accepts result.
- elem_count  out  $clog2(SIZE)+1  acc_en strobes since last capture.
- sel_err  out  1  sticky: load_en seen with memsel==0.
- overrun  out  1  sticky: result dropped because the output register was full.

Behaviour:
- Reset (reset==0, asynchronous) clears all registers. Outputs at reset: result=0, result_valid=0, elem_count=0, sel_err=0, overrun=0.
- Element index = position of the highest set bit of memsel. Non-thermometer patterns use the highest set bit regardless.
- load_en: a_reg<=row_data[idx], b_reg<=col_data[idx].
  - If memsel==0: a_reg=b_reg=0 and sel_err is set.
- mult_en: prod_reg<=a_reg*b_reg, full 2*DATA_W bits, zero-extended to ACC_W.
- acc_en: acc<=acc+prod_reg, and elem_count increments, wrapping at its width.
- Strobes act on independent registers and may coincide. Each stage reads pre-edge values of its source register (pipeline semantics).
- done (single-cycle pulse), when result_valid==0 or result_ready==1 that cycle:
  - result<=final sum, where final sum = acc, or acc+prod_reg if acc_en is also high that cycle.
  - result_valid<=1; acc and elem_count clear to 0.
- done while result_valid==1 and result_ready==0:
  - result is held and the new sum is dropped.
  - overrun is set; acc and elem_count still clear.
- result_valid && result_ready without done: result_valid clears next cycle.
- Handshake and done in the same cycle: the new result loads and result_valid stays 1 (back-to-back, no bubble).
- Latency: the last acc_en edge to result_valid is 1 cycle when done follows, 0 extra cycles when coincident.
- result is stable while result_valid==1 and result_ready==0.
- done with no prior acc_en produces result=0, result_valid=1.
- Reset mid-operation aborts immediately. Partial sums are discarded, and sel_err/overrun clear.
- Accumulation wraps modulo 2^ACC_W unless saturation is compiled in.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: an acc_en sum exceeding 2^ACC_W-1 clamps acc to all-ones. A sticky output sat_flag (1 bit, reset 0, cleared on done capture) is added and set.
- Undefined: the adder wraps modulo 2^ACC_W and the sat_flag port does not exist.

Decomposition:
- Package mac_pkg holds:
  - default DATA_W/SIZE constants;
  - ACC_W derivation function;
  - msb_index function (thermometer → index);
  - the element slice helper.
- One sub-module, memsel_decode: memsel → idx plus a zero flag; it drives the operand muxes.
- The rest stays flat in mac_datapath.

Test Plan:
- Dot product:
  - Stimulus: row=[1,2,3,4], col=[5,6,7,8]; four control-FSM-style load/mult/acc sequences with memsel 0001,0011,0111,1111, then done; result_ready=1.
  - Required: result=70, result_valid for exactly 1 cycle, elem_count back to 0.
- Backpressure:
  - Stimulus: hold result_ready=0; run a second op (row=col=[2,2,2,2]).
  - Required: result stays 70, overrun=1; after ready=1, result_valid drops next cycle.
- Back-to-back:
  - Stimulus: done coincides with result_ready=1 while result_valid=1.
  - Required: new result 16 loads, result_valid stays high with no bubble.
- Select error:
  - Stimulus: load_en with memsel=0000, then mult, acc, done.
  - Required: sel_err=1, result=0.
- Async reset:
  - Stimulus: assert reset low between mult_en and acc_en of element 2.
  - Required: all outputs 0 immediately; a following full op yields 70 with no residue.
- Saturation (MAC_SATURATE_EN, ACC_W=16):
  - Stimulus: row=col=[255,255,255,255] over 2 ops without done in between (8 acc_en).
  - Required: acc clamps to 65535, sat_flag=1.
  - Without the macro, same stimulus: result=520200 mod 65536=61448.
